// File: rtl/stall_flush_ctrl_if.sv
// Pipeline control bundle between the hazard/SRAM side of the pipeline and
// stall_flush_ctrl. master drives the status inputs, slave is the controller.
interface stall_flush_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             has_hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_exe_bubble;
  logic             back_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output has_hazard, branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
           back_freeze, mem_timeout, stall_count
  );

  modport slave (
    input  has_hazard, branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
           back_freeze, mem_timeout, stall_count
  );
endinterface

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: SRAM wait > branch flush > hazard stall.
// SRAM waits longer than TIMEOUT+1 cycles lock into a sticky ERROR state.
// Optional hazard-stall counter enabled by STALL_FLUSH_CTRL_STALL_CNT_EN.
module stall_flush_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  stall_flush_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  logic [1:0] state_q, state_d, cur_st;
  logic [7:0] timer_q, timer_d;
  logic       pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze;
  logic       stall_inc;

  // Reset overrides the registered state so outputs follow RUN rules during rst.
  assign cur_st = rst ? ST_RUN : state_q;

  // Output decode and next-state/timer selection.
  always_comb begin
    state_d       = cur_st;
    timer_d       = timer_q;
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    back_freeze   = 1'b0;
    stall_inc     = 1'b0;
    if (cur_st == ST_ERROR) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      back_freeze  = 1'b1;
    end else if (cur_st == ST_MEM_WAIT && !bus.mem_ready) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      back_freeze  = 1'b1;
      if (timer_q == 8'(TIMEOUT)) begin
        state_d = ST_ERROR;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end else if (cur_st == ST_RUN && bus.mem_req && !bus.mem_ready) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      back_freeze  = 1'b1;
      state_d      = ST_MEM_WAIT;
      timer_d      = 8'd1;
    end else begin
      // Effective RUN: plain RUN, or the MEM_WAIT cycle where SRAM completes.
      if (bus.branch_taken) begin
        if_id_flush   = 1'b1;
        id_exe_bubble = 1'b1;
      end else if (bus.has_hazard) begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_exe_bubble = 1'b1;
        stall_inc     = (cur_st == ST_RUN);
      end
      if (cur_st == ST_MEM_WAIT) begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    end
  end

  // State and wait timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign bus.pc_freeze     = pc_freeze;
  assign bus.if_id_freeze  = if_id_freeze;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_exe_bubble = id_exe_bubble;
  assign bus.back_freeze   = back_freeze;
  assign bus.mem_timeout   = (cur_st == ST_ERROR);

`ifdef STALL_FLUSH_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of hazard-stall cycles in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall_inc && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall_count = cnt_q;
`else
  logic unused_inc;
  assign unused_inc      = stall_inc;
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule
